// File: rtl/cnu_minsum_array.sv
// Six offset-min-sum check node units behind the PE-to-CNU shuffle.
// Two registered stages (capture, output) with valid/ready back-pressure.
module cnu_minsum_array #(
    parameter int DATA_WIDTH = 6,
    parameter int OFFSET     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in [0:35],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out [0:35],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           sat_count
);

    localparam int MW = DATA_WIDTH - 1;
    localparam int NG = 6;
    localparam int GS = 6;
    localparam int NS = NG * GS;
    localparam logic [MW-1:0] OFF = OFFSET[MW-1:0];

    logic [DATA_WIDTH-1:0] s1_data [0:NS-1];
    logic                  s1_valid;
    logic                  s2_valid;
    logic                  adv1;
    logic                  adv2;

    logic [MW-1:0]         min1 [0:NG-1];
    logic [MW-1:0]         min2 [0:NG-1];
    logic [2:0]            idx1 [0:NG-1];
    logic                  sprod [0:NG-1];
    logic [MW-1:0]         sel_mag [0:NS-1];
    logic [MW-1:0]         res_mag [0:NS-1];
    logic [DATA_WIDTH-1:0] next_out [0:NS-1];
    logic [5:0]            sat_inc;

    assign adv2      = s1_valid & (~s2_valid | out_ready);
    assign adv1      = ~s1_valid | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    always_comb begin
        // NOTE: every array written here gets a value before any branch so no latch is inferred;
        // blocking assignments let later loop iterations see earlier partial results.
        for (int g = 0; g < NG; g++) begin
            min1[g]  = s1_data[g*GS][MW-1:0];
            idx1[g]  = 3'd0;
            min2[g]  = '1;
            sprod[g] = 1'b0;
            for (int j = 1; j < GS; j++) begin
                if (s1_data[g*GS+j][MW-1:0] < min1[g]) begin
                    min1[g] = s1_data[g*GS+j][MW-1:0];
                    idx1[g] = 3'(j);
                end
            end
            // Excluding only idx1 makes min2 equal min1 when the minimum is tied.
            for (int j = 0; j < GS; j++) begin
                if (3'(j) != idx1[g] && s1_data[g*GS+j][MW-1:0] < min2[g])
                    min2[g] = s1_data[g*GS+j][MW-1:0];
                sprod[g] = sprod[g] ^ s1_data[g*GS+j][DATA_WIDTH-1];
            end
        end

        sat_inc = '0;
        for (int s = 0; s < NS; s++) begin
            sel_mag[s]  = (3'(s % GS) == idx1[s/GS]) ? min2[s/GS] : min1[s/GS];
            res_mag[s]  = (sel_mag[s] > OFF) ? sel_mag[s] - OFF : '0;
            next_out[s] = '0;
            if (res_mag[s] != '0)
                next_out[s] = {sprod[s/GS] ^ s1_data[s][DATA_WIDTH-1], res_mag[s]};
            if (sel_mag[s] != '0 && sel_mag[s] <= OFF)
                sat_inc = sat_inc + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the stage-1 payload is qualified by s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            for (int s = 0; s < NS; s++)
                s1_data[s] <= data_in[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            sat_count <= '0;
            for (int s = 0; s < NS; s++)
                data_out[s] <= '0;
        end else if (adv2) begin
            s2_valid  <= 1'b1;
            sat_count <= sat_count + 16'(sat_inc);
            for (int s = 0; s < NS; s++)
                data_out[s] <= next_out[s];
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule
